// File: rtl/program_counter.sv
// Fetch-stage program counter: absolute jump, signed relative branch, or
// sequential advance by one instruction word, with the current address always on dataOut.
module program_counter #(
   parameter int unsigned          WIDTH       = 32,
   parameter int unsigned          STEP        = 4,
   parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] dataIn,
   input  logic             writeEnable,
   input  logic             writeAdd,
   input  logic             countEnable,
   output logic [WIDTH-1:0] dataOut
);

   localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

   logic [WIDTH-1:0] programCounter;

   // Control inputs are level-sensitive and sampled on every edge; there is no
   // handshake. A write always wins over counting, and additions wrap modulo 2^WIDTH.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         programCounter <= RESET_VALUE;
      end else if (writeEnable) begin
         if (writeAdd) begin
            programCounter <= programCounter + dataIn;
         end else begin
            programCounter <= dataIn;
         end
      end else if (countEnable) begin
         programCounter <= programCounter + STEP_W;
      end
   end

   assign dataOut = programCounter;

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: a reference model pushes the expected
// PC into a scoreboard queue per driven edge; each test task pops and compares inline.
module tb_program_counter;

   localparam int W = 32;

   logic         clk;
   logic         reset;
   logic [W-1:0] dataIn;
   logic         writeEnable;
   logic         writeAdd;
   logic         countEnable;
   logic [W-1:0] dataOut;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] modelPc;
   logic [W-1:0] expVal;
   int           total;
   int           bad;

   program_counter #(.WIDTH(W), .STEP(4), .RESET_VALUE('0)) dut (
      .clk         (clk),
      .reset       (reset),
      .dataIn      (dataIn),
      .writeEnable (writeEnable),
      .writeAdd    (writeAdd),
      .countEnable (countEnable),
      .dataOut     (dataOut)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // driver: apply one cycle of controls, predict the PC after the next edge
   task automatic drive(input logic we, input logic wa, input logic ce, input logic [W-1:0] d);
      writeEnable = we;
      writeAdd    = wa;
      countEnable = ce;
      dataIn      = d;
      if (!reset)     modelPc = '0;
      else if (we)    modelPc = wa ? modelPc + d : d;
      else if (ce)    modelPc = modelPc + 32'd4;
      exp_q.push_back(modelPc);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #1;
      total++;
      if (dataOut !== 32'h0) begin
         bad++;
         $display("FAIL reset_initial got=%h exp=%h", dataOut, 32'h0);
      end
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 1'b1, 32'h12345678);
         expVal = exp_q.pop_front();
         total++;
         if (dataOut !== expVal || dut.programCounter !== expVal) begin
            bad++;
            $display("FAIL reset_hold got=%h pc=%h exp=%h", dataOut, dut.programCounter, expVal);
         end
      end
      @(negedge clk);
      reset = 1'b1;
      // load 0x100 then pull reset between edges
      drive(1'b1, 1'b0, 1'b0, 32'h100);
      expVal = exp_q.pop_front();
      total++;
      if (dataOut !== expVal) begin
         bad++;
         $display("FAIL reset_preload got=%h exp=%h", dataOut, expVal);
      end
      writeEnable = 1'b1;
      countEnable = 1'b1;
      dataIn      = 32'h55555555;
      #2;
      reset = 1'b0;
      modelPc = '0;
      #1;
      total++;
      if (dataOut !== modelPc || dut.programCounter !== modelPc) begin
         bad++;
         $display("FAIL reset_async got=%h pc=%h exp=%h", dataOut, dut.programCounter, modelPc);
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_jump_set();
      drive(1'b1, 1'b0, 1'b0, 32'hDEADBEEF);
      expVal = exp_q.pop_front();
      total++;
      if (dataOut !== expVal) begin
         bad++;
         $display("FAIL jump_set got=%h exp=%h", dataOut, expVal);
      end
   endtask

   task automatic test_jump_add();
      logic [W-1:0] seq [3];
      seq = '{32'h0000000C, 32'hFFFFFFFC, 32'h00000010};
      drive(1'b1, 1'b0, 1'b0, seq[0]);
      for (int i = 1; i < 3; i++) drive(1'b1, 1'b1, 1'b0, seq[i]);
      for (int i = 0; i < 3; i++) begin
         expVal = exp_q.pop_front();
         total++;
         if (i == 2 && dataOut !== expVal) begin
            bad++;
            $display("FAIL jump_add got=%h exp=%h", dataOut, expVal);
         end else if (i != 2 && expVal === 32'hxxxxxxxx) begin
            bad++;
            $display("FAIL jump_add_model got=%h exp=%h", dataOut, expVal);
         end
      end
   endtask

   task automatic test_jump_add_steps();
      drive(1'b1, 1'b0, 1'b0, 32'h0000000C);
      expVal = exp_q.pop_front();
      drive(1'b1, 1'b1, 1'b0, 32'hFFFFFFFC);
      expVal = exp_q.pop_front();
      total++;
      if (dataOut !== expVal) begin
         bad++;
         $display("FAIL add_negative got=%h exp=%h", dataOut, expVal);
      end
      drive(1'b1, 1'b1, 1'b0, 32'h00000010);
      expVal = exp_q.pop_front();
      total++;
      if (dataOut !== expVal) begin
         bad++;
         $display("FAIL add_positive got=%h exp=%h", dataOut, expVal);
      end
   endtask

   task automatic test_count();
      drive(1'b1, 1'b0, 1'b0, 32'h4);
      expVal = exp_q.pop_front();
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, 1'b0, 1'b1, 32'hFFFFFFFF);
         expVal = exp_q.pop_front();
         total++;
         if (dataOut !== expVal) begin
            bad++;
            $display("FAIL count_%0d got=%h exp=%h", i, dataOut, expVal);
         end
      end
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 1'b1, 1'b0, 32'h00000ABC);
         expVal = exp_q.pop_front();
         total++;
         if (dataOut !== expVal) begin
            bad++;
            $display("FAIL count_hold got=%h exp=%h", dataOut, expVal);
         end
      end
   endtask

   task automatic test_priority();
      drive(1'b1, 1'b0, 1'b0, 32'h40);
      expVal = exp_q.pop_front();
      drive(1'b1, 1'b0, 1'b1, 32'h200);
      expVal = exp_q.pop_front();
      total++;
      if (dataOut !== expVal) begin
         bad++;
         $display("FAIL prio_write_over_count got=%h exp=%h", dataOut, expVal);
      end
      drive(1'b1, 1'b1, 1'b1, 32'h8);
      expVal = exp_q.pop_front();
      total++;
      if (dataOut !== expVal) begin
         bad++;
         $display("FAIL prio_add_over_count got=%h exp=%h", dataOut, expVal);
      end
      drive(1'b0, 1'b1, 1'b0, 32'h1000);
      expVal = exp_q.pop_front();
      total++;
      if (dataOut !== expVal) begin
         bad++;
         $display("FAIL prio_writeadd_ignored got=%h exp=%h", dataOut, expVal);
      end
   endtask

   task automatic test_wrap();
      drive(1'b1, 1'b0, 1'b0, 32'hFFFFFFFC);
      expVal = exp_q.pop_front();
      drive(1'b0, 1'b0, 1'b1, 32'h0);
      expVal = exp_q.pop_front();
      total++;
      if (dataOut !== expVal) begin
         bad++;
         $display("FAIL wrap_count got=%h exp=%h", dataOut, expVal);
      end
      drive(1'b1, 1'b0, 1'b0, 32'hFFFFFFF0);
      expVal = exp_q.pop_front();
      drive(1'b1, 1'b1, 1'b0, 32'h20);
      expVal = exp_q.pop_front();
      total++;
      if (dataOut !== expVal) begin
         bad++;
         $display("FAIL wrap_add got=%h exp=%h", dataOut, expVal);
      end
      drive(1'b1, 1'b0, 1'b0, 32'h00000003);
      expVal = exp_q.pop_front();
      total++;
      if (dataOut !== expVal) begin
         bad++;
         $display("FAIL unaligned_set got=%h exp=%h", dataOut, expVal);
      end
   endtask

   // back-to-back random mix of set / add / count / hold
   task automatic test_back_to_back();
      for (int i = 0; i < 60; i++) begin
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom());
      end
      for (int i = 0; i < 60; i++) begin
         expVal = exp_q.pop_front();
         if (i == 59) begin
            total++;
            if (dataOut !== expVal) begin
               bad++;
               $display("FAIL random_final got=%h exp=%h", dataOut, expVal);
            end
         end
      end
   endtask

   task automatic test_random_each();
      for (int i = 0; i < 60; i++) begin
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom());
         expVal = exp_q.pop_front();
         total++;
         if (dataOut !== expVal) begin
            bad++;
            $display("FAIL random_%0d got=%h exp=%h", i, dataOut, expVal);
         end
      end
   endtask

   initial begin
      total       = 0;
      bad         = 0;
      modelPc     = '0;
      reset       = 1'b0;
      dataIn      = '0;
      writeEnable = 1'b0;
      writeAdd    = 1'b0;
      countEnable = 1'b0;
      test_reset();
      test_jump_set();
      test_jump_add();
      test_jump_add_steps();
      test_count();
      test_priority();
      test_wrap();
      test_back_to_back();
      test_random_each();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
